// File: rtl/detector_scheduler.sv
// Round-robin scheduler sharing one serial four-ones detector among NREQ requesters.
// Optional macro DETECTOR_SCHED_EARLY_EXIT_EN: end a frame as soon as the detector fires.
module detector_scheduler #(
   parameter int NREQ      = 4,
   parameter int FRAME_LEN = 8,
   parameter int IDW       = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] frame_bit,
   output logic [NREQ-1:0] grant,
   output logic            det_reset,
   output logic            det_in,
   input  logic            det_out,
   output logic            done,
   output logic [IDW-1:0]  done_id,
   output logic            hit
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_STREAM = 3'd2,
      S_FLUSH  = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   localparam logic [7:0] LAST_BIT = 8'(FRAME_LEN - 1);

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic            done_q, done_d;
   logic [IDW-1:0]  done_id_q, done_id_d;
   logic            hit_q, hit_d;
   logic [IDW-1:0]  win_q, win_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;

   logic            found_s;
   logic [IDW-1:0]  pick_s;
   logic [IDW-1:0]  idx_s;

   // Rotating priority search: first pending request at or above ptr, wrapping.
   always_comb begin
      found_s = 1'b0;
      pick_s  = {IDW{1'b0}};
      idx_s   = {IDW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         idx_s = IDW'((int'(ptr_q) + i) % NREQ);
         if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            pick_s  = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      hit_d     = hit_q;
      win_d     = win_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (found_s) begin
               win_d   = pick_s;
               grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
               hit_d   = 1'b0;
               state_d = S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            cnt_d   = 8'd0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            cnt_d = cnt_q + 8'd1;
            // Detector output lags its input, so the first stream cycle still shows the cleared state.
            if (cnt_q != 8'd0) begin
               hit_d = hit_q | det_out;
            end else begin
               hit_d = hit_q;
            end
`ifdef DETECTOR_SCHED_EARLY_EXIT_EN
            if ((cnt_q != 8'd0) && det_out) begin
               grant_d   = {NREQ{1'b0}};
               done_d    = 1'b1;
               done_id_d = win_q;
               state_d   = S_REPORT;
            end else if (cnt_q == LAST_BIT) begin
               state_d = S_FLUSH;
            end else begin
               state_d = S_STREAM;
            end
`else
            if (cnt_q == LAST_BIT) begin
               state_d = S_FLUSH;
            end else begin
               state_d = S_STREAM;
            end
`endif
         end
         S_FLUSH: begin
            hit_d     = hit_q | det_out;
            grant_d   = {NREQ{1'b0}};
            done_d    = 1'b1;
            done_id_d = win_q;
            state_d   = S_REPORT;
         end
         S_REPORT: begin
            if (win_q == IDW'(NREQ - 1)) begin
               ptr_d = {IDW{1'b0}};
            end else begin
               ptr_d = win_q + IDW'(1);
            end
            state_d = S_IDLE;
         end
         default: begin
            grant_d = {NREQ{1'b0}};
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         grant_q   <= {NREQ{1'b0}};
         done_q    <= 1'b0;
         done_id_q <= {IDW{1'b0}};
         hit_q     <= 1'b0;
         win_q     <= {IDW{1'b0}};
         ptr_q     <= {IDW{1'b0}};
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         hit_q     <= hit_d;
         win_q     <= win_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign hit       = hit_q;
   assign det_reset = reset | (state_q == S_CLEAR);
   assign det_in    = (state_q == S_STREAM) ? frame_bit[win_q] : 1'b0;

endmodule

// File: tb/tb_detector_scheduler.sv
// Directed testbench for detector_scheduler; models the four-ones detector locally.
module tb_detector_scheduler;

   localparam int FL = 8;
`ifdef DETECTOR_SCHED_EARLY_EXIT_EN
   localparam int EE = 1;
`else
   localparam int EE = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] frame_bit;
   logic [3:0] grant;
   logic       det_reset;
   logic       det_in;
   logic       det_out;
   logic       done;
   logic [1:0] done_id;
   logic       hit;

   int checks   = 0;
   int failures = 0;

   detector_scheduler #(.NREQ(4), .FRAME_LEN(FL), .IDW(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .frame_bit (frame_bit),
      .grant     (grant),
      .det_reset (det_reset),
      .det_in    (det_in),
      .det_out   (det_out),
      .done      (done),
      .done_id   (done_id),
      .hit       (hit)
   );

   always #5 clk = ~clk;

   // Reference four-ones detector: output high once four consecutive ones have been clocked in.
   logic [2:0] run_q = 3'd0;
   always @(posedge clk) begin
      if (det_reset)               run_q <= 3'd0;
      else if (!det_in)            run_q <= 3'd0;
      else if (run_q != 3'd4)      run_q <= run_q + 3'd1;
   end
   assign det_out = (run_q == 3'd4);

   // One frame starting with the IDLE cycle t (c=0); bits are LSB-first (bits[0] is bit k=0).
   task automatic run_frame(input string name, input logic [3:0] reqv, input logic [7:0] bits,
                            input logic [3:0] exp_g, input int done_at, input logic exp_hit,
                            input logic [1:0] exp_id, input logic drop);
      int         s_end;
      logic [3:0] g_exp;
      logic       din_exp;
      s_end = (done_at == 3 + FL) ? 1 + FL : done_at - 1;
      for (int c = 0; c <= done_at; c++) begin
         req = reqv;
         if (drop && c == done_at) req = 4'b0000;
         din_exp   = (c >= 2 && c <= s_end) ? bits[c-2] : 1'b0;
         frame_bit = {4{din_exp}};
         @(negedge clk);
         g_exp = (c >= 1 && c <= done_at - 1) ? exp_g : 4'b0000;
         checks++;
         if (grant !== g_exp) begin
            failures++;
            $display("FAIL %s grant c=%0d got=%b exp=%b", name, c, grant, g_exp);
         end
         checks++;
         if (done !== (c == done_at)) begin
            failures++;
            $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, (c == done_at));
         end
         checks++;
         if (det_reset !== (c == 1)) begin
            failures++;
            $display("FAIL %s det_reset c=%0d got=%b exp=%b", name, c, det_reset, (c == 1));
         end
         checks++;
         if (det_in !== din_exp) begin
            failures++;
            $display("FAIL %s det_in c=%0d got=%b exp=%b", name, c, det_in, din_exp);
         end
         if (c == done_at) begin
            checks++;
            if (done_id !== exp_id) begin
               failures++;
               $display("FAIL %s done_id got=%0d exp=%0d", name, done_id, exp_id);
            end
            checks++;
            if (hit !== exp_hit) begin
               failures++;
               $display("FAIL %s hit got=%b exp=%b", name, hit, exp_hit);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      req = 4'b0000;
      frame_bit = 4'b0000;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({grant, done, done_id, hit, det_in} !== 9'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b", {grant, done, done_id, hit, det_in}, 9'b0);
      end
      checks++;
      if (det_reset !== 1'b1) begin
         failures++;
         $display("FAIL reset_det_reset got=%b exp=1", det_reset);
      end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (det_reset !== 1'b0) begin
         failures++;
         $display("FAIL idle_det_reset got=%b exp=0", det_reset);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_hit_run();
      run_frame("hit_run", 4'b0001, 8'b0000_1111, 4'b0001, (EE != 0) ? 7 : 11, 1'b1, 2'd0, 1'b1);
   endtask

   task automatic test_no_run();
      run_frame("no_run", 4'b0001, 8'b0111_0111, 4'b0001, 11, 1'b0, 2'd0, 1'b1);
   endtask

   task automatic test_last_bit();
      run_frame("last_bit", 4'b0001, 8'b1111_0000, 4'b0001, 11, 1'b1, 2'd0, 1'b1);
   endtask

   task automatic test_early_exit();
      run_frame("all_ones", 4'b0001, 8'b1111_1111, 4'b0001, (EE != 0) ? 7 : 11, 1'b1, 2'd0, 1'b1);
   endtask

   task automatic test_round_robin();
      reset_dut();
      run_frame("rr0", 4'b0101, 8'h00, 4'b0001, 11, 1'b0, 2'd0, 1'b0);
      run_frame("rr1", 4'b0101, 8'h00, 4'b0100, 11, 1'b0, 2'd2, 1'b0);
      run_frame("rr2", 4'b0101, 8'h00, 4'b0001, 11, 1'b0, 2'd0, 1'b0);
      run_frame("rr3", 4'b0101, 8'h00, 4'b0100, 11, 1'b0, 2'd2, 1'b1);
   endtask

   task automatic test_reset_abort();
      // Leave ptr at 2 so a reset that failed to clear it would favour requester 2.
      run_frame("pre_abort", 4'b0010, 8'h00, 4'b0010, 11, 1'b0, 2'd1, 1'b1);
      req = 4'b0100;
      frame_bit = 4'b1111;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0100) begin
         failures++;
         $display("FAIL abort_grant_before got=%b exp=0100", grant);
      end
      checks++;
      if (det_reset !== 1'b1) begin
         failures++;
         $display("FAIL abort_det_reset got=%b exp=1", det_reset);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      req = 4'b0000;
      frame_bit = 4'b0000;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (grant !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet c=%0d grant=%b done=%b exp grant=0000 done=0", c, grant, done);
         end
         @(posedge clk); #1;
      end
      run_frame("post_abort", 4'b0110, 8'h00, 4'b0010, 11, 1'b0, 2'd1, 1'b1);
   endtask

   initial begin
      reset = 1'b1;
      req = 4'b0000;
      frame_bit = 4'b0000;
      test_reset();
      test_hit_run();
      test_no_run();
      test_last_bit();
      test_early_exit();
      test_round_robin();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/detector_scheduler.md
# detector_scheduler

Round-robin scheduler that time-shares one serial four-ones run detector (`detector4bits`) among `NREQ` requesters. A granted requester streams a fixed-length frame of `FRAME_LEN` bits through the detector. The scheduler clears the detector before each frame, records whether a run of four consecutive ones occurred, and returns a per-frame result to the requester. It sits between the requester bank and the single detector instance and owns the detector's `in_bit` and `reset`.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `FRAME_LEN`, default 8: bits per frame, range 1..255.
- `IDW`, default `$clog2(NREQ)`: width of requester index.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  per-requester frame request; level, held until `done` for that requester.
- `frame_bit`  in  NREQ  serial data from each requester; only the granted lane is used.
- `grant`  out  NREQ  one-hot grant, registered; all zero when idle.
- `det_reset`  out  1  drives the detector's synchronous reset.
- `det_in`  out  1  drives the detector's `in_bit`.
- `det_out`  in  1  detector's `out_bit` (high in run state).
- `done`  out  1  one-cycle pulse: frame result valid.
- `done_id`  out  IDW  index of the finished requester, valid with `done`.
- `hit`  out  1  1 if `det_out` was seen high during the frame; valid with `done`.

## Operation
- FSM states: IDLE, CLEAR, STREAM, FLUSH, REPORT.
- IDLE:
  - If `req` is non-zero, the winner is the first set bit searched from `ptr` upward, wrapping modulo `NREQ`.
  - Latch `win`, set `grant[win]`, clear `hit`, go to CLEAR.
  - If `req` is zero, stay in IDLE.
- CLEAR, one cycle:
  - `det_reset` = 1, `det_in` = 0, `det_out` ignored.
  - Load bit counter with 0, go to STREAM.
- STREAM, `FRAME_LEN` cycles:
  - `det_in` = `frame_bit[win]`; counter increments each cycle.
  - `hit` |= `det_out` in every STREAM cycle except the first, since the detector output lags its input by one cycle.
  - When counter = `FRAME_LEN`-1, go to FLUSH.
- FLUSH, one cycle:
  - `det_in` = 0, `hit` |= `det_out` to capture the last bit's effect.
  - `grant` drops to 0 at the end of FLUSH.
- REPORT, one cycle:
  - `done` = 1, `done_id` = `win`, `hit` = latched value.
  - `ptr` ← (`win`+1) mod `NREQ`; go to IDLE.
- `det_reset` = `reset` OR (state == CLEAR), so reset of this block also clears the detector.
- In all states other than STREAM, `det_in` = 0.
- Deassertion of `req[win]` during CLEAR/STREAM/FLUSH is ignored; the frame completes and reports.
- A requester that is still asserting `req` after its `done` competes again, behind the other requesters.

## Timing
- Reset values: state IDLE, `grant` = 0, `done` = 0, `done_id` = 0, `hit` = 0, `det_in` = 0, `ptr` = 0 (requester 0 highest priority).
- `det_reset` = 1 while `reset` is high.
- Let `req` be seen in IDLE at cycle t:
  - `grant` is high from t+1 through t+2+`FRAME_LEN`.
  - CLEAR is at t+1; STREAM spans t+2..t+1+`FRAME_LEN`; FLUSH is at t+2+`FRAME_LEN`.
  - `done` pulses at t+3+`FRAME_LEN`.
  - The earliest next grant is at t+5+`FRAME_LEN`.
- Requester must present `frame_bit` bit k (k=0..`FRAME_LEN`-1) in cycle t+2+k, i.e. in the k-th cycle after `grant` rises plus one.
- Reset asserted mid-frame: on the next edge the FSM returns to IDLE, `grant` = 0, no `done` for the aborted frame, and `ptr` = 0.
- Simultaneous requests: only one grant; priority rotates per completed frame, which prevents starvation.

## Configuration
- `DETECTOR_SCHED_EARLY_EXIT_EN`
  - Defined: in STREAM, the first cycle `det_out` = 1 sets `hit` and jumps directly to REPORT on the next edge, skipping the remaining bits and FLUSH. `grant` drops when REPORT is entered; the requester must tolerate a truncated frame.
  - Undefined: frames always run the full `FRAME_LEN` + FLUSH; `det_out` never changes control flow.

## Test plan
- `FRAME_LEN`=8, `req`=0001 at t, bits 1,1,1,1,0,0,0,0 → `grant`=0001 t+1..t+10, `done`@t+11, `done_id`=0, `hit`=1.
- Same, bits 1,1,1,0,1,1,1,0 → `done`@t+11, `hit`=0, and `det_reset` high exactly at t+1.
- Last-bit boundary: bits 0,0,0,0,1,1,1,1 → `hit`=1 (captured in FLUSH).
- `req`=0101 held → `grant` sequence 0001, 0100, 0001, 0100; `done_id` 0,2,0,2; never two grants set.
- `reset` pulsed in STREAM cycle 3 → next cycle `grant`=0, `done` stays 0, `det_reset`=1. A later `req`=0110 is granted to requester 1 first.
- With `DETECTOR_SCHED_EARLY_EXIT_EN`, bits 1,1,1,1,1,1,1,1 → `done`@t+7 with `hit`=1. Without the macro → `done`@t+11.
